// File: rtl/ball_rally_fsm.sv
// ball_rally_fsm
//   Game engine for a two-player LED "ball rally". The ball walks from
//   position 0 (player A end) to POS_MAX (player B end), one step per tick.
//   A player returns the ball by pressing while it sits at their own end.
//   If a player misses, that player's lost flag is raised for HOLD_TICKS
//   ticks, and then that player serves.
//
//   Optional feature macro: SCORE_BOARD_EN
//     Defined   : adds score keeping, a match limit (WIN_SCORE) and the OVER state.
//     Undefined : scoreA, scoreB and game_over are tied to 0, and play is endless.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   tick       one-cycle step pulse (one ball step per pulse)
//   on         game enable; 0 forces IDLE in any cycle
//   btnA/btnB  raw asynchronous active-high player buttons
//   state      ball position 0..POS_MAX (registered)
//   lostA/B    miss flags, held for HOLD_TICKS ticks (registered)
//   scoreA/B   points won (registered, 0 without SCORE_BOARD_EN)
//   game_over  match decided (registered, 0 without SCORE_BOARD_EN)
//   dbg_fsm    current FSM state encoding, for observation only
//
// Interface timing
//   tick, pA and pB are single-cycle qualifiers. The FSM samples them on
//   the rising clock edge. A press pulse is consumed on the 3rd clock edge
//   after the raw button rises. A press that arrives in the same cycle as
//   a tick is evaluated against the ball position from before that tick.
module ball_rally_fsm #(
    parameter int POS_MAX    = 5,
    parameter int HOLD_TICKS = 3,
    parameter int SCORE_W    = 4,
    parameter int WIN_SCORE  = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               on,
    input  logic               btnA,
    input  logic               btnB,
    output logic [2:0]         state,
    output logic               lostA,
    output logic               lostB,
    output logic [SCORE_W-1:0] scoreA,
    output logic [SCORE_W-1:0] scoreB,
    output logic               game_over,
    output logic [2:0]         dbg_fsm
);

    typedef enum logic [2:0] {
        IDLE, SERVE_A, SERVE_B, MOVE_R, MOVE_L, LOST_A, LOST_B, OVER
    } fsm_t;

    localparam logic [2:0] END_B      = 3'(POS_MAX);
    localparam logic [2:0] NEAR_B     = 3'(POS_MAX - 1);
    localparam int         HOLD_W     = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    fsm_t              fsm;
    logic [2:0]        sync_a;
    logic [2:0]        sync_b;
    logic              pA;
    logic              pB;
    logic              hA;
    logic              hB;
    logic [HOLD_W-1:0] hold_cnt;
    logic              match_won;

    assign dbg_fsm = fsm;

    // Bits [1:0] form the two-flop synchroniser. Bit [2] holds the
    // previous synchronised level and is used for rising-edge detection.
    // A held button therefore gives exactly one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[1:0], btnA};
            sync_b <= {sync_b[1:0], btnB};
        end
    end

    assign pA = sync_a[1] & ~sync_a[2];
    assign pB = sync_b[1] & ~sync_b[2];

`ifdef SCORE_BOARD_EN
    assign match_won = (scoreA == SCORE_W'(WIN_SCORE)) || (scoreB == SCORE_W'(WIN_SCORE));
`else
    assign match_won = 1'b0;
    assign scoreA    = '0;
    assign scoreB    = '0;
    assign game_over = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= IDLE;
            state    <= '0;
            lostA    <= 1'b0;
            lostB    <= 1'b0;
            hA       <= 1'b0;
            hB       <= 1'b0;
            hold_cnt <= '0;
`ifdef SCORE_BOARD_EN
            scoreA    <= '0;
            scoreB    <= '0;
            game_over <= 1'b0;
`endif
        end else if (!on) begin
            fsm      <= IDLE;
            state    <= '0;
            lostA    <= 1'b0;
            lostB    <= 1'b0;
            hA       <= 1'b0;
            hB       <= 1'b0;
            hold_cnt <= '0;
`ifdef SCORE_BOARD_EN
            scoreA    <= '0;
            scoreB    <= '0;
            game_over <= 1'b0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    fsm   <= SERVE_A;
                    state <= '0;
                end
                SERVE_A: begin
                    state <= '0;
                    if (pA) fsm <= MOVE_R;
                end
                SERVE_B: begin
                    state <= END_B;
                    if (pB) fsm <= MOVE_L;
                end
                MOVE_R: begin
                    if (tick) begin
                        hB <= 1'b0;
                        if (state != END_B) begin
                            state <= state + 3'd1;
                        end else if (hB || pB) begin
                            fsm   <= MOVE_L;
                            state <= NEAR_B;
                        end else begin
                            fsm      <= LOST_B;
                            lostB    <= 1'b1;
                            hold_cnt <= '0;
`ifdef SCORE_BOARD_EN
                            if (scoreA != SCORE_W'(WIN_SCORE)) scoreA <= scoreA + 1'b1;
`endif
                        end
                    end else if (state == END_B && pB) begin
                        // Latch an early return. Only a press made while the
                        // ball waits at the end counts; a press on the arrival
                        // tick does not.
                        hB <= 1'b1;
                    end
                end
                MOVE_L: begin
                    if (tick) begin
                        hA <= 1'b0;
                        if (state != 3'd0) begin
                            state <= state - 3'd1;
                        end else if (hA || pA) begin
                            fsm   <= MOVE_R;
                            state <= 3'd1;
                        end else begin
                            fsm      <= LOST_A;
                            lostA    <= 1'b1;
                            hold_cnt <= '0;
`ifdef SCORE_BOARD_EN
                            if (scoreB != SCORE_W'(WIN_SCORE)) scoreB <= scoreB + 1'b1;
`endif
                        end
                    end else if (state == 3'd0 && pA) begin
                        hA <= 1'b1;
                    end
                end
                LOST_A: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            lostA    <= 1'b0;
                            hold_cnt <= '0;
                            fsm      <= match_won ? OVER : SERVE_A;
`ifdef SCORE_BOARD_EN
                            if (match_won) game_over <= 1'b1;
`endif
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                LOST_B: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            lostB    <= 1'b0;
                            hold_cnt <= '0;
                            fsm      <= match_won ? OVER : SERVE_B;
`ifdef SCORE_BOARD_EN
                            if (match_won) game_over <= 1'b1;
`endif
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                OVER: begin
                    // Terminal state. Only on=0 or reset leaves it.
                    fsm <= OVER;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_rally_fsm.sv
// tb_ball_rally_fsm
//   Drives ticks, button presses and the enable input. After each game
//   action, a game-level reference model predicts the visible outputs and
//   pushes them to a scoreboard. A monitor compares them against the DUT.
module tb_ball_rally_fsm;

    localparam int POS_MAX = 5;
    localparam int HOLD    = 3;
    localparam int WIN     = 7;
    localparam int SW      = 4;

    localparam int PH_IDLE  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_RALLY = 2;
    localparam int PH_LOST  = 3;
    localparam int PH_OVER  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          on;
    logic          btnA;
    logic          btnB;
    logic [2:0]    state;
    logic          lostA;
    logic          lostB;
    logic [SW-1:0] scoreA;
    logic [SW-1:0] scoreB;
    logic          game_over;
    logic [2:0]    dbg_fsm;

    ball_rally_fsm #(
        .POS_MAX(POS_MAX), .HOLD_TICKS(HOLD), .SCORE_W(SW), .WIN_SCORE(WIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .on(on), .btnA(btnA), .btnB(btnB),
        .state(state), .lostA(lostA), .lostB(lostB), .scoreA(scoreA),
        .scoreB(scoreB), .game_over(game_over), .dbg_fsm(dbg_fsm)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [13:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    event        chk_ev;

    initial begin
        forever begin
            logic [13:0] exp_v;
            logic [13:0] got_v;
            string       nm;
            @(chk_ev);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got output with no expectation, required a queued entry");
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                got_v = {state, lostA, lostB, scoreA, scoreB, game_over};
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL %s: got state=%0d lostA=%0b lostB=%0b scoreA=%0d scoreB=%0d over=%0b, required state=%0d lostA=%0b lostB=%0b scoreA=%0d scoreB=%0d over=%0b",
                             nm, got_v[13:11], got_v[10], got_v[9], got_v[8:5], got_v[4:1], got_v[0],
                             exp_v[13:11], exp_v[10], exp_v[9], exp_v[8:5], exp_v[4:1], exp_v[0]);
                end
            end
        end
    end

    // ---------------- reference model (game level) ----------------
    int m_phase, m_pos, m_dir, m_hold, m_server, m_loser, m_sa, m_sb;
    bit m_hit;

    function automatic void m_clear();
        m_phase = PH_IDLE; m_pos = 0; m_dir = 0; m_hold = 0;
        m_server = 0; m_loser = 0; m_sa = 0; m_sb = 0; m_hit = 0;
    endfunction

    function automatic void m_enable();
        if (m_phase == PH_IDLE) begin
            m_phase = PH_SERVE; m_server = 0; m_pos = 0;
        end
    endfunction

    // who: 0 = player A, 1 = player B
    function automatic void m_press(input int who);
        if (m_phase == PH_SERVE && who == m_server) begin
            m_phase = PH_RALLY;
            m_dir   = (who == 0) ? 1 : -1;
            m_hit   = 0;
        end else if (m_phase == PH_RALLY &&
                     ((who == 1 && m_dir > 0 && m_pos == POS_MAX) ||
                      (who == 0 && m_dir < 0 && m_pos == 0))) begin
            m_hit = 1;
        end
    endfunction

    // who: player pressing in the same cycle as the tick, -1 for none
    function automatic void m_tick(input int who);
        int returner;
        if (m_phase == PH_RALLY) begin
            returner = (m_dir > 0) ? 1 : 0;
            if (!((m_dir > 0 && m_pos == POS_MAX) || (m_dir < 0 && m_pos == 0))) begin
                m_pos = m_pos + m_dir;
            end else if (m_hit || who == returner) begin
                m_dir = -m_dir;
                m_pos = m_pos + m_dir;
            end else begin
                m_phase = PH_LOST;
                m_loser = returner;
                m_hold  = 0;
`ifdef SCORE_BOARD_EN
                if (returner == 1) m_sa = (m_sa < WIN) ? m_sa + 1 : WIN;
                else               m_sb = (m_sb < WIN) ? m_sb + 1 : WIN;
`endif
            end
            m_hit = 0;
        end else if (m_phase == PH_LOST) begin
            m_hold++;
            if (m_hold == HOLD) begin
                if (m_sa == WIN || m_sb == WIN) m_phase = PH_OVER;
                else begin
                    m_phase  = PH_SERVE;
                    m_server = m_loser;
                end
            end
        end
    endfunction

    function automatic void m_press_tick(input int who);
        if (m_phase == PH_SERVE)      m_press(who);
        else if (m_phase == PH_RALLY) m_tick(who);
        else                          m_tick(-1);
    endfunction

    function automatic logic [13:0] m_expect();
        logic la;
        logic lb;
        la = (m_phase == PH_LOST) && (m_loser == 0);
        lb = (m_phase == PH_LOST) && (m_loser == 1);
        return {3'(m_pos), la, lb, 4'(m_sa), 4'(m_sb), (m_phase == PH_OVER)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check(input string nm);
        exp_q.push_back(m_expect());
        name_q.push_back(nm);
        -> chk_ev;
        #1;
    endtask

    task automatic drive_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        m_tick(-1);
    endtask

    // The button rises at a falling edge and its pulse is consumed on the
    // third rising edge. with_tick places a tick on that same edge.
    task automatic press(input int who, input int hold, input bit with_tick);
        @(negedge clk);
        if (who == 0) btnA = 1'b1; else btnB = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (with_tick) tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (hold) @(negedge clk);
        btnA = 1'b0;
        btnB = 1'b0;
        repeat (3) @(negedge clk);
        if (with_tick) m_press_tick(who); else m_press(who);
    endtask

    task automatic set_on(input logic v);
        @(negedge clk); on = v;
        @(negedge clk);
        @(negedge clk);
        if (!v) m_clear(); else m_enable();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; on = 1'b0; btnA = 1'b0; btnB = 1'b0; tick = 1'b0;
        m_clear();
        repeat (3) @(negedge clk);
        check("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_when_off");
        set_on(1'b1);
        check("enable_serve_a");

        // Full rally: A serves, the ball runs to 5, B returns early, the
        // ball runs back to 0.
        press(0, 2, 1'b0);
        check("serve_a_press");
        for (int i = 0; i < 5; i++) begin
            drive_tick();
            check("rally_right");
        end
        press(1, 2, 1'b0);
        check("early_hit_b");
        for (int i = 0; i < 5; i++) begin
            drive_tick();
            check("rally_left");
        end
        // A press coincident with the departure tick at 0 is accepted.
        press(0, 1, 1'b1);
        check("departure_hit_a");
        for (int i = 0; i < 4; i++) begin
            drive_tick();
            check("rally_right2");
        end
        // Miss: no return at 5.
        drive_tick();
        check("miss_b_lost");
        for (int i = 0; i < HOLD; i++) begin
            drive_tick();
            check("lost_b_hold");
        end

        // B serves. The ball goes to 0 and A returns on departure. B then
        // presses on the arrival tick, which is ignored.
        press(1, 3, 1'b0);
        check("serve_b_press");
        for (int i = 0; i < 5; i++) begin
            drive_tick();
            check("serve_b_left");
        end
        press(0, 0, 1'b1);
        check("departure_hit_a2");
        for (int i = 0; i < 3; i++) begin
            drive_tick();
            check("to_four");
        end
        press(1, 0, 1'b1);
        check("arrival_press_b");
        drive_tick();
        check("arrival_press_ignored");
        for (int i = 0; i < HOLD; i++) begin
            drive_tick();
            check("lost_b_hold2");
        end

        // A held button gives one pulse. That pulse arrives at state 2 while
        // the ball moves left, so it must not count as a return.
        press(1, 1, 1'b0);
        for (int i = 0; i < 3; i++) drive_tick();
        check("at_two_moving_left");
        @(negedge clk); btnA = 1'b1;
        repeat (3) @(negedge clk);
        m_press(0);
        drive_tick();
        drive_tick();
        check("held_a_at_zero");
        repeat (990) @(negedge clk);
        btnA = 1'b0;
        repeat (3) @(negedge clk);
        drive_tick();
        check("held_button_single_pulse");
        for (int i = 0; i < HOLD; i++) drive_tick();
        check("serve_a_after_lost_a");

        // Asynchronous reset in the middle of a rally.
        press(0, 1, 1'b0);
        drive_tick();
        drive_tick();
        @(negedge clk); rst_n = 1'b0;
        #1;
        m_clear();
        check("async_reset_mid_rally");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        m_enable();
        check("serve_after_reset");

        // Enable dropped in the middle of a rally.
        press(0, 1, 1'b0);
        drive_tick();
        set_on(1'b0);
        check("off_mid_rally");
        set_on(1'b1);
        check("on_again");

`ifdef SCORE_BOARD_EN
        // B misses repeatedly until the match ends.
        for (int n = 0; n < 2 * WIN && m_phase != PH_OVER; n++) begin
            if (m_server == 0) begin
                press(0, 1, 1'b0);
                repeat (5) drive_tick();
            end else begin
                press(1, 1, 1'b0);
                repeat (5) drive_tick();
                press(0, 0, 1'b1);
                repeat (4) drive_tick();
            end
            drive_tick();
            check("score_miss_b");
            repeat (HOLD) drive_tick();
            check("score_after_hold");
        end
        drive_tick();
        check("over_frozen");
        set_on(1'b0);
        check("over_cleared_by_off");
        set_on(1'b1);
`endif

        // Randomized play.
        for (int i = 0; i < 300; i++) begin
            int r;
            if (on == 1'b0 && $urandom_range(0, 2) == 0) begin
                set_on(1'b1);
                check("rand_on");
            end
            r = $urandom_range(0, 99);
            if (r < 45) begin
                drive_tick();
            end else if (r < 65) begin
                press(0, $urandom_range(0, 6), ($urandom_range(0, 9) < 3));
            end else if (r < 85) begin
                press(1, $urandom_range(0, 6), ($urandom_range(0, 9) < 3));
            end else if (r < 97) begin
                if (m_phase == PH_RALLY)
                    press((m_dir > 0) ? 1 : 0, $urandom_range(0, 4), ($urandom_range(0, 1) == 1));
                else if (m_phase == PH_SERVE)
                    press(m_server, $urandom_range(0, 4), 1'b0);
                else
                    drive_tick();
            end else begin
                set_on(~on);
            end
            check("random_step");
        end

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
